// File: rtl/boot_ram_v2.sv
// boot_ram_v2: unified instruction/data RAM with a framed UART boot loader.
// Frame format: SYNC_BYTE, len[7:0], len[15:8], len payload bytes, checksum.
// A good checksum releases the CPU; fetching HALT_WORD re-arms the loader.
module boot_ram_v2 #(
    parameter int unsigned     LOGD      = 10,
    parameter int unsigned     DW        = 32,
    parameter logic [7:0]      SYNC_BYTE = 8'hA5,
    parameter logic [DW-1:0]   HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [31:0]       rd_addr,
    output logic [DW-1:0]     rd_data,
    input  logic [31:0]       pc_addr,
    output logic [DW-1:0]     pc_data,
    input  logic [31:0]       wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_strb,
    input  logic              wr_valid,
    output logic              cpu_running,
    output logic              load_busy,
    output logic              load_err
);
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned LB    = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned DEPTH = 1 << LOGD;
    localparam logic [31:0] CAP   = 32'(NB) << LOGD;

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [DW-1:0] mem [0:DEPTH-1];

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        run_q, run_d;
    logic        ld_we;
    logic        cpu_we;
    logic [15:0] len_new;
    logic [31:0] cnt_ext, ld_word, ld_lane;

    // High address bits alias; only the word-index field selects storage.
    assign rd_data = mem[rd_addr[LB +: LOGD]];
    assign pc_data = mem[pc_addr[LB +: LOGD]];

    assign cpu_running = run_q;
    assign load_busy   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                         (state_q == S_DATA) || (state_q == S_CSUM);
    assign load_err    = (state_q == S_ERR);

    assign cpu_we  = wr_valid && !wr_addr[31] && run_q;
    assign len_new = {rx_data, len_q[7:0]};
    assign cnt_ext = {16'd0, cnt_q};
    assign ld_word = cnt_ext / NB;
    assign ld_lane = cnt_ext % NB;

    logic unused_bits;
    assign unused_bits = &{1'b0, rd_addr, pc_addr, wr_addr, ld_word};

    // Loader FSM next-state: one rx byte per transition, halt check in RUN.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        run_d   = run_q;
        ld_we   = 1'b0;
        case (state_q)
            S_SYNC: if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN0;
            S_LEN0: if (rx_valid) begin
                len_d[7:0] = rx_data;
                state_d    = S_LEN1;
            end
            S_LEN1: if (rx_valid) begin
                len_d  = len_new;
                cnt_d  = '0;
                csum_d = '0;
                if (len_new == 16'd0)            state_d = S_CSUM;
                else if ({16'd0, len_new} > CAP) state_d = S_ERR;
                else                             state_d = S_DATA;
            end
            S_DATA: if (rx_valid) begin
                ld_we  = 1'b1;
                csum_d = csum_q + rx_data;
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == len_q - 16'd1) state_d = S_CSUM;
            end
            S_CSUM: if (rx_valid) begin
                if (rx_data == csum_q) begin
                    state_d = S_RUN;
                    run_d   = 1'b1;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_RUN: if (pc_data == HALT_WORD) begin
                state_d = S_SYNC;
                run_d   = 1'b0;
            end
            S_ERR: if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN0;
            default: state_d = S_SYNC;
        endcase
    end

    // Control state registers; memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= S_SYNC;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            run_q   <= run_d;
        end
    end

    // Memory write: byte-strobed CPU store in RUN, loader byte otherwise.
    // A loader byte on lane 0 clears the rest of the word so short tails read as zero.
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            for (int i = 0; i < int'(NB); i++)
                if (wr_strb[i]) mem[wr_addr[LB +: LOGD]][8*i +: 8] <= wr_data[8*i +: 8];
        end else if (ld_we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (32'(i) == ld_lane)   mem[ld_word[LOGD-1:0]][8*i +: 8] <= rx_data;
                else if (ld_lane == 0)   mem[ld_word[LOGD-1:0]][8*i +: 8] <= 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_boot_ram_v2.sv
// Directed bench for boot_ram_v2 (LOGD=10, DW=32).
module tb_boot_ram_v2;
    logic        clk = 1'b0;
    logic        i_reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] rd_addr, pc_addr, wr_addr;
    logic [31:0] rd_data, pc_data, wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid;
    logic        cpu_running, load_busy, load_err;

    int checks = 0;
    int failures = 0;

    boot_ram_v2 dut (
        .clk(clk), .i_reset(i_reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .pc_addr(pc_addr), .pc_data(pc_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid),
        .cpu_running(cpu_running), .load_busy(load_busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // one-cycle strobe; returns on the negedge after the consuming posedge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wr_addr = a; wr_data = d; wr_strb = s; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        checks++;
        if ({cpu_running, load_busy, load_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000", {cpu_running, load_busy, load_err});
        end
    endtask

    task automatic test_good_frame;
        logic [31:0] w;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        checks++;
        if ({cpu_running, load_busy} !== 2'b01) begin
            failures++;
            $display("FAIL frame_before_csum run/busy got=%b want=01", {cpu_running, load_busy});
        end
        send_byte(8'hFF);
        checks++;
        if ({cpu_running, load_busy, load_err} !== 3'b100) begin
            failures++;
            $display("FAIL frame_after_csum run/busy/err got=%b want=100", {cpu_running, load_busy, load_err});
        end
        read_word(32'd0, w);
        checks++;
        if (w !== 32'h44332211) begin failures++; $display("FAIL frame_word0 got=%h want=44332211", w); end
        read_word(32'd4, w);
        checks++;
        if (w !== 32'h00000055) begin failures++; $display("FAIL frame_word1 got=%h want=00000055", w); end
    endtask

    task automatic test_cpu_store;
        logic [31:0] w;
        cpu_store(32'd4, 32'hAABBCCDD, 4'b0101);
        read_word(32'd4, w);
        checks++;
        if (w !== 32'h00BB00DD) begin failures++; $display("FAIL store_strobe got=%h want=00BB00DD", w); end
        cpu_store(32'h8000_0004, 32'h12345678, 4'b1111);
        read_word(32'd4, w);
        checks++;
        if (w !== 32'h00BB00DD) begin failures++; $display("FAIL store_mmio got=%h want=00BB00DD", w); end
        // high non-MMIO bits alias onto the same word
        cpu_store(32'h0000_1004, 32'h000000EE, 4'b0001);
        read_word(32'd4, w);
        checks++;
        if (w !== 32'h00BB00EE) begin failures++; $display("FAIL store_alias got=%h want=00BB00EE", w); end
    endtask

    task automatic test_halt;
        logic [31:0] w;
        cpu_store(32'd12, 32'hFFFFFFFF, 4'b1111);
        @(negedge clk);
        pc_addr = 32'd12;
        @(negedge clk);
        checks++;
        if ({cpu_running, load_busy, load_err} !== 3'b000) begin
            failures++;
            $display("FAIL halt_stop got=%b want=000", {cpu_running, load_busy, load_err});
        end
        cpu_store(32'd4, 32'h12345678, 4'b1111);
        read_word(32'd4, w);
        checks++;
        if (w !== 32'h00BB00EE) begin failures++; $display("FAIL store_not_running got=%h want=00BB00EE", w); end
        pc_addr = 32'd0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h77); send_byte(8'h77);
        checks++;
        if (cpu_running !== 1'b1) begin failures++; $display("FAIL rerun got=%b want=1", cpu_running); end
        read_word(32'd0, w);
        checks++;
        if (w !== 32'h00000077) begin failures++; $display("FAIL rerun_word0 got=%h want=00000077", w); end
        pc_addr = 32'd12;
        @(negedge clk);
        checks++;
        if (cpu_running !== 1'b0) begin failures++; $display("FAIL halt_again got=%b want=0", cpu_running); end
        pc_addr = 32'd0;
    endtask

    task automatic test_bad_csum;
        logic [31:0] w;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        send_byte(8'h00);
        checks++;
        if ({cpu_running, load_busy, load_err} !== 3'b001) begin
            failures++;
            $display("FAIL bad_csum got=%b want=001", {cpu_running, load_busy, load_err});
        end
        send_byte(8'h3C);
        checks++;
        if (load_err !== 1'b1) begin failures++; $display("FAIL err_ignores_byte got=%b want=1", load_err); end
        send_byte(8'hA5);
        checks++;
        if ({load_busy, load_err} !== 2'b10) begin
            failures++;
            $display("FAIL err_resync got=%b want=10", {load_busy, load_err});
        end
        send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        send_byte(8'hFF);
        checks++;
        if (cpu_running !== 1'b1) begin failures++; $display("FAIL recover_run got=%b want=1", cpu_running); end
        read_word(32'd4, w);
        checks++;
        if (w !== 32'h00000055) begin failures++; $display("FAIL recover_word1 got=%h want=00000055", w); end
        pc_addr = 32'd12;
        @(negedge clk);
        pc_addr = 32'd0;
    endtask

    task automatic test_len_bounds;
        logic [31:0] w;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        checks++;
        if ({load_busy, load_err} !== 2'b01) begin
            failures++;
            $display("FAIL len_overflow got=%b want=01", {load_busy, load_err});
        end
        send_byte(8'h99);
        read_word(32'd0, w);
        checks++;
        if (w !== 32'h44332211) begin failures++; $display("FAIL len_overflow_nowrite got=%h want=44332211", w); end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if ({cpu_running, load_busy} !== 2'b01) begin
            failures++;
            $display("FAIL len0_to_csum got=%b want=01", {cpu_running, load_busy});
        end
        send_byte(8'h00);
        checks++;
        if (cpu_running !== 1'b1) begin failures++; $display("FAIL len0_run got=%b want=1", cpu_running); end
        pc_addr = 32'd12;
        @(negedge clk);
        pc_addr = 32'd0;
    endtask

    task automatic test_reset_midframe;
        send_byte(8'h00); send_byte(8'hA5);
        checks++;
        if (load_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b want=1", load_busy); end
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        checks++;
        if ({cpu_running, load_busy, load_err} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset got=%b want=000", {cpu_running, load_busy, load_err});
        end
        send_byte(8'h42);
        checks++;
        if (load_busy !== 1'b0) begin failures++; $display("FAIL mid_sync_discard got=%b want=0", load_busy); end
        send_byte(8'hA5);
        checks++;
        if (load_busy !== 1'b1) begin failures++; $display("FAIL mid_restart got=%b want=1", load_busy); end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (cpu_running !== 1'b1) begin failures++; $display("FAIL mid_finish_run got=%b want=1", cpu_running); end
    endtask

    initial begin
        i_reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        rd_addr = '0; pc_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_valid = 1'b0;
        test_reset();
        test_good_frame();
        test_cpu_store();
        test_halt();
        test_bad_csum();
        test_len_bounds();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
